// File: rtl/procyon_lsu_issue_arb_pkg.sv
// Shared LSU constants and arbiter source encodings for the LSU issue arbiter slice.
package procyon_lsu_issue_arb_pkg;

  localparam int PCYN_LSU_FUNC_WIDTH = 4;

  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_LB   = 4'b0000;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_LH   = 4'b0001;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_LW   = 4'b0010;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_LBU  = 4'b0011;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_LHU  = 4'b0100;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_SB   = 4'b0101;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_SH   = 4'b0110;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_SW   = 4'b0111;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_FILL = 4'b1000;

  localparam int PCYN_LSU_ARB_SRC_WIDTH = 2;

  typedef enum logic [PCYN_LSU_ARB_SRC_WIDTH-1:0] {
    PCYN_LSU_ARB_SRC_FILL = 2'd0,
    PCYN_LSU_ARB_SRC_SQ   = 2'd1,
    PCYN_LSU_ARB_SRC_LQ   = 2'd2,
    PCYN_LSU_ARB_SRC_RS   = 2'd3
  } pcyn_lsu_arb_src_t;

endpackage

// File: rtl/procyon_lsu_issue_arb_starve_cnt.sv
// Saturating RS starvation counter; o_starved is asserted once the count reaches the limit.
module procyon_lsu_starve_cnt #(
  parameter int OPTN_STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_clear,
  input  logic       i_inc,
  output logic       o_starved,
  output logic [3:0] o_count
);

  localparam logic [3:0] LIMIT = 4'(OPTN_STARVE_LIMIT);

  logic [3:0] r_count;

  // Clear has priority so a flush or RS grant always restarts the count.
  always_ff @(posedge clk) begin
    if (!n_rst || i_clear) r_count <= '0;
    else if (i_inc && (r_count != LIMIT)) r_count <= r_count + 4'd1;
  end

  assign o_starved = (r_count == LIMIT);
  assign o_count   = r_count;

endmodule

// File: rtl/procyon_lsu_issue_arb.sv
// LSU issue arbiter: fill > starved RS > SQ > LQ > RS, registered single-op output.
// Optional grant performance counters are enabled with `define PCYN_LSU_ARB_PERF_EN.
module procyon_lsu_issue_arb
  import procyon_lsu_issue_arb_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_LQ_DEPTH      = 8,
  parameter int OPTN_SQ_DEPTH      = 8,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  parameter int OPTN_STARVE_LIMIT  = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           i_flush,
  input  logic                           i_fill_en,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_fill_addr,
  input  logic                           i_sq_retire_en,
  input  logic [PCYN_LSU_FUNC_WIDTH-1:0] i_sq_retire_lsu_func,
  input  logic [OPTN_SQ_DEPTH-1:0]       i_sq_retire_select,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]  i_sq_retire_tag,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_sq_retire_addr,
  output logic                           o_sq_retire_stall,
  input  logic                           i_lq_replay_en,
  input  logic [PCYN_LSU_FUNC_WIDTH-1:0] i_lq_replay_lsu_func,
  input  logic [OPTN_LQ_DEPTH-1:0]       i_lq_replay_select,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]  i_lq_replay_tag,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_lq_replay_addr,
  output logic                           o_lq_replay_stall,
  input  logic                           i_rs_en,
  input  logic [PCYN_LSU_FUNC_WIDTH-1:0] i_rs_lsu_func,
  input  logic [OPTN_LQ_DEPTH-1:0]       i_rs_lq_select,
  input  logic [OPTN_SQ_DEPTH-1:0]       i_rs_sq_select,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]  i_rs_tag,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_rs_addr,
  output logic                           o_rs_stall,
  output logic                           o_valid,
  output logic                           o_fill_replay,
  output logic                           o_retire,
  output logic [PCYN_LSU_FUNC_WIDTH-1:0] o_lsu_func,
  output logic [OPTN_LQ_DEPTH-1:0]       o_lq_select,
  output logic [OPTN_SQ_DEPTH-1:0]       o_sq_select,
  output logic [OPTN_ROB_IDX_WIDTH-1:0]  o_tag,
  output logic [OPTN_ADDR_WIDTH-1:0]     o_addr
`ifdef PCYN_LSU_ARB_PERF_EN
  ,
  output logic [31:0]                    o_perf_fill_cnt,
  output logic [31:0]                    o_perf_sq_cnt,
  output logic [31:0]                    o_perf_lq_cnt,
  output logic [31:0]                    o_perf_rs_cnt,
  output logic [31:0]                    o_perf_force_cnt
`endif
);

  logic w_starved;
  logic [3:0] w_starve_count;
  logic w_gnt_fill, w_gnt_force, w_gnt_sq, w_gnt_lq, w_gnt_rs, w_gnt_any;
  pcyn_lsu_arb_src_t w_src;

  logic [PCYN_LSU_FUNC_WIDTH-1:0] w_func;
  logic [OPTN_LQ_DEPTH-1:0]       w_lq_select;
  logic [OPTN_SQ_DEPTH-1:0]       w_sq_select;
  logic [OPTN_ROB_IDX_WIDTH-1:0]  w_tag;
  logic [OPTN_ADDR_WIDTH-1:0]     w_addr;

  logic r_valid, r_fill_replay, r_retire;
  logic [PCYN_LSU_FUNC_WIDTH-1:0] r_func;
  logic [OPTN_LQ_DEPTH-1:0]       r_lq_select;
  logic [OPTN_SQ_DEPTH-1:0]       r_sq_select;
  logic [OPTN_ROB_IDX_WIDTH-1:0]  r_tag;
  logic [OPTN_ADDR_WIDTH-1:0]     r_addr;

  assign w_gnt_fill  = i_fill_en;
  assign w_gnt_force = ~i_fill_en & w_starved & i_rs_en;
  assign w_gnt_sq    = ~i_fill_en & ~w_gnt_force & i_sq_retire_en;
  assign w_gnt_lq    = ~i_fill_en & ~w_gnt_force & ~i_sq_retire_en & i_lq_replay_en;
  assign w_gnt_rs    = ~i_fill_en & (w_gnt_force | (~i_sq_retire_en & ~i_lq_replay_en & i_rs_en));
  assign w_gnt_any   = w_gnt_fill | w_gnt_sq | w_gnt_lq | w_gnt_rs;

  assign o_sq_retire_stall = i_sq_retire_en & ~w_gnt_sq;
  assign o_lq_replay_stall = i_lq_replay_en & ~w_gnt_lq;
  assign o_rs_stall        = i_rs_en & ~w_gnt_rs;

  procyon_lsu_starve_cnt #(
    .OPTN_STARVE_LIMIT(OPTN_STARVE_LIMIT)
  ) u_starve_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_clear  (i_flush | ~i_rs_en | w_gnt_rs),
    .i_inc    (i_rs_en & o_rs_stall),
    .o_starved(w_starved),
    .o_count  (w_starve_count)
  );

  always_comb begin
    if (w_gnt_fill)    w_src = PCYN_LSU_ARB_SRC_FILL;
    else if (w_gnt_sq) w_src = PCYN_LSU_ARB_SRC_SQ;
    else if (w_gnt_lq) w_src = PCYN_LSU_ARB_SRC_LQ;
    else               w_src = PCYN_LSU_ARB_SRC_RS;
  end

  always_comb begin
    w_func      = i_rs_lsu_func;
    w_lq_select = i_rs_lq_select;
    w_sq_select = i_rs_sq_select;
    w_tag       = i_rs_tag;
    w_addr      = i_rs_addr;
    case (w_src)
      PCYN_LSU_ARB_SRC_FILL: begin
        w_func      = PCYN_LSU_FUNC_FILL;
        w_lq_select = '0;
        w_sq_select = '0;
        w_tag       = '0;
        w_addr      = i_fill_addr;
      end
      PCYN_LSU_ARB_SRC_SQ: begin
        w_func      = i_sq_retire_lsu_func;
        w_lq_select = '0;
        w_sq_select = i_sq_retire_select;
        w_tag       = i_sq_retire_tag;
        w_addr      = i_sq_retire_addr;
      end
      PCYN_LSU_ARB_SRC_LQ: begin
        w_func      = i_lq_replay_lsu_func;
        w_lq_select = i_lq_replay_select;
        w_sq_select = '0;
        w_tag       = i_lq_replay_tag;
        w_addr      = i_lq_replay_addr;
      end
      default: ;
    endcase
  end

  // Fills bypass the flush since the MHQ cannot re-request a line.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_valid       <= 1'b0;
      r_fill_replay <= 1'b0;
      r_retire      <= 1'b0;
    end else begin
      r_valid       <= w_gnt_fill | (w_gnt_any & ~i_flush);
      r_fill_replay <= w_gnt_fill;
      r_retire      <= w_gnt_sq & ~i_flush;
    end
  end

  always_ff @(posedge clk) begin
    r_func      <= w_func;
    r_lq_select <= w_lq_select;
    r_sq_select <= w_sq_select;
    r_tag       <= w_tag;
    r_addr      <= w_addr;
  end

  assign o_valid       = r_valid;
  assign o_fill_replay = r_fill_replay;
  assign o_retire      = r_retire;
  assign o_lsu_func    = r_func;
  assign o_lq_select   = r_lq_select;
  assign o_sq_select   = r_sq_select;
  assign o_tag         = r_tag;
  assign o_addr        = r_addr;

`ifdef PCYN_LSU_ARB_PERF_EN
  logic [31:0] r_perf_fill_cnt, r_perf_sq_cnt, r_perf_lq_cnt, r_perf_rs_cnt, r_perf_force_cnt;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_perf_fill_cnt  <= '0;
      r_perf_sq_cnt    <= '0;
      r_perf_lq_cnt    <= '0;
      r_perf_rs_cnt    <= '0;
      r_perf_force_cnt <= '0;
    end else begin
      r_perf_fill_cnt  <= r_perf_fill_cnt  + 32'(w_gnt_fill);
      r_perf_sq_cnt    <= r_perf_sq_cnt    + 32'(w_gnt_sq);
      r_perf_lq_cnt    <= r_perf_lq_cnt    + 32'(w_gnt_lq);
      r_perf_rs_cnt    <= r_perf_rs_cnt    + 32'(w_gnt_rs);
      r_perf_force_cnt <= r_perf_force_cnt + 32'(w_gnt_force);
    end
  end

  assign o_perf_fill_cnt  = r_perf_fill_cnt;
  assign o_perf_sq_cnt    = r_perf_sq_cnt;
  assign o_perf_lq_cnt    = r_perf_lq_cnt;
  assign o_perf_rs_cnt    = r_perf_rs_cnt;
  assign o_perf_force_cnt = r_perf_force_cnt;
`endif

endmodule

// File: tb/tb_procyon_lsu_issue_arb.sv
// Self-checking bench for procyon_lsu_issue_arb: directed table, starvation sequences, random vs model.
module tb_procyon_lsu_issue_arb;
  import procyon_lsu_issue_arb_pkg::*;

  localparam int LIMIT = 4;
  localparam int SRC_NONE = 0, SRC_FILL = 1, SRC_SQ = 2, SRC_LQ = 3, SRC_RS = 4;

  logic clk = 1'b0;
  logic n_rst;
  logic i_flush, i_fill_en, i_sq_retire_en, i_lq_replay_en, i_rs_en;
  logic [31:0] i_fill_addr, i_sq_retire_addr, i_lq_replay_addr, i_rs_addr;
  logic [3:0]  i_sq_retire_lsu_func, i_lq_replay_lsu_func, i_rs_lsu_func;
  logic [7:0]  i_sq_retire_select, i_lq_replay_select, i_rs_lq_select, i_rs_sq_select;
  logic [4:0]  i_sq_retire_tag, i_lq_replay_tag, i_rs_tag;
  logic o_sq_retire_stall, o_lq_replay_stall, o_rs_stall;
  logic o_valid, o_fill_replay, o_retire;
  logic [3:0]  o_lsu_func;
  logic [7:0]  o_lq_select, o_sq_select;
  logic [4:0]  o_tag;
  logic [31:0] o_addr;
`ifdef PCYN_LSU_ARB_PERF_EN
  logic [31:0] o_perf_fill_cnt, o_perf_sq_cnt, o_perf_lq_cnt, o_perf_rs_cnt, o_perf_force_cnt;
`endif

  procyon_lsu_issue_arb #(.OPTN_STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .n_rst(n_rst), .i_flush(i_flush),
    .i_fill_en(i_fill_en), .i_fill_addr(i_fill_addr),
    .i_sq_retire_en(i_sq_retire_en), .i_sq_retire_lsu_func(i_sq_retire_lsu_func),
    .i_sq_retire_select(i_sq_retire_select), .i_sq_retire_tag(i_sq_retire_tag),
    .i_sq_retire_addr(i_sq_retire_addr), .o_sq_retire_stall(o_sq_retire_stall),
    .i_lq_replay_en(i_lq_replay_en), .i_lq_replay_lsu_func(i_lq_replay_lsu_func),
    .i_lq_replay_select(i_lq_replay_select), .i_lq_replay_tag(i_lq_replay_tag),
    .i_lq_replay_addr(i_lq_replay_addr), .o_lq_replay_stall(o_lq_replay_stall),
    .i_rs_en(i_rs_en), .i_rs_lsu_func(i_rs_lsu_func), .i_rs_lq_select(i_rs_lq_select),
    .i_rs_sq_select(i_rs_sq_select), .i_rs_tag(i_rs_tag), .i_rs_addr(i_rs_addr),
    .o_rs_stall(o_rs_stall),
    .o_valid(o_valid), .o_fill_replay(o_fill_replay), .o_retire(o_retire),
    .o_lsu_func(o_lsu_func), .o_lq_select(o_lq_select), .o_sq_select(o_sq_select),
    .o_tag(o_tag), .o_addr(o_addr)
`ifdef PCYN_LSU_ARB_PERF_EN
    , .o_perf_fill_cnt(o_perf_fill_cnt), .o_perf_sq_cnt(o_perf_sq_cnt),
    .o_perf_lq_cnt(o_perf_lq_cnt), .o_perf_rs_cnt(o_perf_rs_cnt),
    .o_perf_force_cnt(o_perf_force_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit fill, sq, lq, rs, flush;
    logic [31:0] fillAddr, sqAddr, lqAddr, rsAddr;
    logic [3:0]  sqFunc, lqFunc, rsFunc;
    logic [7:0]  sqSel, lqSel, rsLqSel, rsSqSel;
    logic [4:0]  sqTag, lqTag, rsTag;
  } req_t;

  typedef struct {
    bit fill, sq, lq, rs, flush;
    bit expSqStall, expLqStall, expRsStall;
    bit expValid, expFillReplay, expRetire;
    int expSrc;
    int expCount;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic req_t makeReq(bit fill, bit sq, bit lq, bit rs, bit flush);
    req_t r;
    r.fill = fill; r.sq = sq; r.lq = lq; r.rs = rs; r.flush = flush;
    r.fillAddr = 32'h1000;
    r.sqAddr = 32'h2000; r.sqFunc = PCYN_LSU_FUNC_SW; r.sqSel = 8'h04; r.sqTag = 5'd3;
    r.lqAddr = 32'h3000; r.lqFunc = PCYN_LSU_FUNC_LW; r.lqSel = 8'h10; r.lqTag = 5'd5;
    r.rsAddr = 32'h4000; r.rsFunc = PCYN_LSU_FUNC_LB; r.rsLqSel = 8'h01; r.rsSqSel = 8'h80;
    r.rsTag = 5'd7;
    return r;
  endfunction

  task automatic applyStimulus(input req_t r);
    @(negedge clk);
    i_flush = r.flush;
    i_fill_en = r.fill; i_fill_addr = r.fillAddr;
    i_sq_retire_en = r.sq; i_sq_retire_addr = r.sqAddr; i_sq_retire_lsu_func = r.sqFunc;
    i_sq_retire_select = r.sqSel; i_sq_retire_tag = r.sqTag;
    i_lq_replay_en = r.lq; i_lq_replay_addr = r.lqAddr; i_lq_replay_lsu_func = r.lqFunc;
    i_lq_replay_select = r.lqSel; i_lq_replay_tag = r.lqTag;
    i_rs_en = r.rs; i_rs_addr = r.rsAddr; i_rs_lsu_func = r.rsFunc;
    i_rs_lq_select = r.rsLqSel; i_rs_sq_select = r.rsSqSel; i_rs_tag = r.rsTag;
  endtask

  // Applies one cycle of requests, checks stalls before the edge and outputs/counter after it.
  task automatic stepCheck(input string name, input req_t r, input bit sqSt, input bit lqSt,
                           input bit rsSt, input int src, input bit valid, input bit fr,
                           input bit ret, input int count);
    logic [3:0] eFunc;
    logic [31:0] eAddr;
    logic [7:0] eLq, eSq;
    logic [4:0] eTag;
    applyStimulus(r);
    #1;
    checkOutput({name, " sq_stall"}, 32'(o_sq_retire_stall), 32'(sqSt));
    checkOutput({name, " lq_stall"}, 32'(o_lq_replay_stall), 32'(lqSt));
    checkOutput({name, " rs_stall"}, 32'(o_rs_stall), 32'(rsSt));
    @(posedge clk);
    #1;
    checkOutput({name, " valid"}, 32'(o_valid), 32'(valid));
    checkOutput({name, " fill_replay"}, 32'(o_fill_replay), 32'(fr));
    checkOutput({name, " retire"}, 32'(o_retire), 32'(ret));
    checkOutput({name, " starve_cnt"}, 32'(dut.u_starve_cnt.o_count), 32'(count));
    if (valid) begin
      case (src)
        SRC_FILL: begin eFunc = PCYN_LSU_FUNC_FILL; eAddr = r.fillAddr; eLq = 0; eSq = 0; eTag = 0; end
        SRC_SQ:   begin eFunc = r.sqFunc; eAddr = r.sqAddr; eLq = 0; eSq = r.sqSel; eTag = r.sqTag; end
        SRC_LQ:   begin eFunc = r.lqFunc; eAddr = r.lqAddr; eLq = r.lqSel; eSq = 0; eTag = r.lqTag; end
        default:  begin eFunc = r.rsFunc; eAddr = r.rsAddr; eLq = r.rsLqSel; eSq = r.rsSqSel; eTag = r.rsTag; end
      endcase
      checkOutput({name, " func"}, 32'(o_lsu_func), 32'(eFunc));
      checkOutput({name, " addr"}, o_addr, eAddr);
      checkOutput({name, " lq_sel"}, 32'(o_lq_select), 32'(eLq));
      checkOutput({name, " sq_sel"}, 32'(o_sq_select), 32'(eSq));
      checkOutput({name, " tag"}, 32'(o_tag), 32'(eTag));
    end
  endtask

  task automatic doReset();
    applyStimulus(makeReq(0, 0, 0, 0, 0));
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  // Reference model: priority rules with the starvation count held as a plain integer.
  function automatic int pickWinner(input req_t r, input int starve);
    if (r.fill) return SRC_FILL;
    if (starve == LIMIT && r.rs) return SRC_RS;
    if (r.sq) return SRC_SQ;
    if (r.lq) return SRC_LQ;
    if (r.rs) return SRC_RS;
    return SRC_NONE;
  endfunction

  function automatic req_t randReq();
    req_t r;
    r = makeReq(0, 0, 0, 0, 0);
    r.fillAddr = $urandom; r.sqAddr = $urandom; r.lqAddr = $urandom; r.rsAddr = $urandom;
    r.sqFunc = 4'($urandom_range(5, 7)); r.lqFunc = 4'($urandom_range(0, 4));
    r.rsFunc = 4'($urandom_range(0, 7));
    r.sqSel = 8'(1 << $urandom_range(0, 7)); r.lqSel = 8'(1 << $urandom_range(0, 7));
    r.rsLqSel = 8'(1 << $urandom_range(0, 7)); r.rsSqSel = 8'(1 << $urandom_range(0, 7));
    r.sqTag = 5'($urandom); r.lqTag = 5'($urandom); r.rsTag = 5'($urandom);
    return r;
  endfunction

  vec_t table_q[$];

  initial begin
    req_t cur, nxt;
    int starve, win, nextStarve;
    n_rst = 1'b0;
    doReset();

    // Reset state before any request
    #1;
    checkOutput("reset valid", 32'(o_valid), 32'd0);
    checkOutput("reset fill_replay", 32'(o_fill_replay), 32'd0);
    checkOutput("reset retire", 32'(o_retire), 32'd0);
    checkOutput("reset starve_cnt", 32'(dut.u_starve_cnt.o_count), 32'd0);

    //            fill sq lq rs fl  sqS lqS rsS val fr ret src       cnt
    table_q.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SRC_NONE, 0});
    table_q.push_back('{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0, SRC_FILL, 1});
    table_q.push_back('{0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1, SRC_SQ,   2});
    table_q.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, SRC_LQ,   0});
    table_q.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, SRC_RS,   0});
    table_q.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, SRC_RS,   0});
    table_q.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, SRC_FILL, 0});
    table_q.push_back('{0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1, SRC_SQ,   0});
    table_q.push_back('{0, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, SRC_SQ,   0});
    table_q.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SRC_NONE, 0});
    foreach (table_q[i]) begin
      vec_t v;
      v = table_q[i];
      stepCheck($sformatf("vec%0d", i), makeReq(v.fill, v.sq, v.lq, v.rs, v.flush),
                v.expSqStall, v.expLqStall, v.expRsStall, v.expSrc, v.expValid,
                v.expFillReplay, v.expRetire, v.expCount);
    end

    // LQ replay and RS held: RS is forced through on the fifth cycle
    for (int c = 1; c <= 4; c++)
      stepCheck($sformatf("starveLq%0d", c), makeReq(0, 0, 1, 1, 0), 0, 0, 1, SRC_LQ, 1, 0, 0, c);
    stepCheck("starveLqForce", makeReq(0, 0, 1, 1, 0), 0, 1, 0, SRC_RS, 1, 0, 0, 0);

    // Fill pre-empts a forced grant and the counter holds saturated
    for (int c = 1; c <= 4; c++)
      stepCheck($sformatf("starveSq%0d", c), makeReq(0, 1, 0, 1, 0), 0, 0, 1, SRC_SQ, 1, 0, 1, c);
    stepCheck("starveFillPreempt", makeReq(1, 1, 0, 1, 0), 1, 0, 1, SRC_FILL, 1, 1, 0, LIMIT);
    stepCheck("starveSqForce", makeReq(0, 1, 0, 1, 0), 1, 0, 0, SRC_RS, 1, 0, 0, 0);

    // Randomized traffic; stalled requesters keep their fields until granted
    doReset();
    starve = 0;
    cur = randReq();
    for (int n = 0; n < 600; n++) begin
      cur.fill  = ($urandom_range(0, 4) == 0);
      cur.flush = ($urandom_range(0, 15) == 0);
      win = pickWinner(cur, starve);
      if (cur.flush || !cur.rs || win == SRC_RS) nextStarve = 0;
      else nextStarve = (starve < LIMIT) ? starve + 1 : starve;
      stepCheck($sformatf("rand%0d", n), cur,
                cur.sq && win != SRC_SQ, cur.lq && win != SRC_LQ, cur.rs && win != SRC_RS,
                win, (win == SRC_FILL) || (win != SRC_NONE && !cur.flush),
                win == SRC_FILL, win == SRC_SQ && !cur.flush, nextStarve);
      starve = nextStarve;
      nxt = randReq();
      if (!cur.flush && cur.sq && win != SRC_SQ) begin
        nxt.sqAddr = cur.sqAddr; nxt.sqFunc = cur.sqFunc; nxt.sqSel = cur.sqSel; nxt.sqTag = cur.sqTag;
        nxt.sq = 1;
      end else nxt.sq = ($urandom_range(0, 2) == 0);
      if (!cur.flush && cur.lq && win != SRC_LQ) begin
        nxt.lqAddr = cur.lqAddr; nxt.lqFunc = cur.lqFunc; nxt.lqSel = cur.lqSel; nxt.lqTag = cur.lqTag;
        nxt.lq = 1;
      end else nxt.lq = ($urandom_range(0, 2) == 0);
      if (!cur.flush && cur.rs && win != SRC_RS) begin
        nxt.rsAddr = cur.rsAddr; nxt.rsFunc = cur.rsFunc; nxt.rsLqSel = cur.rsLqSel;
        nxt.rsSqSel = cur.rsSqSel; nxt.rsTag = cur.rsTag;
        nxt.rs = 1;
      end else nxt.rs = ($urandom_range(0, 1) == 0);
      cur = nxt;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/procyon_lsu_issue_arb.md
Name: procyon_lsu_issue_arb

Overview:
- Single-ported arbiter in front of the LSU address/dcache pipeline; one op per cycle enters the execute stage.
- Four requesters:
  - MHQ cache-line fills
  - SQ retiring stores
  - LQ replays of missed loads
  - new ops from the LSU reservation station (RS)
- Fixed priority plus an anti-starvation counter that protects RS forward progress.
- Output is registered and drives the address/dcache stage inputs directly.

Parameters:
- OPTN_DATA_WIDTH, 32, data width (passed through for package consistency)
- OPTN_ADDR_WIDTH, 32, address width
- OPTN_LQ_DEPTH, 8, LQ entries (one-hot select width)
- OPTN_SQ_DEPTH, 8, SQ entries (one-hot select width)
- OPTN_ROB_IDX_WIDTH, 5, ROB tag width
- OPTN_STARVE_LIMIT, 4, consecutive denied RS cycles before RS is force-granted (1..15)

Ports:
- clk  in  1  clock
- n_rst  in  1  synchronous active-low reset
- i_flush  in  1  pipeline flush
- i_fill_en  in  1  fill request (never stalled)
- i_fill_addr  in  OPTN_ADDR_WIDTH  fill line address
- i_sq_retire_en  in  1  SQ retire request
- i_sq_retire_lsu_func  in  PCYN_LSU_FUNC_WIDTH  store func
- i_sq_retire_select  in  OPTN_SQ_DEPTH  one-hot SQ entry
- i_sq_retire_tag  in  OPTN_ROB_IDX_WIDTH  ROB tag
- i_sq_retire_addr  in  OPTN_ADDR_WIDTH  store address
- o_sq_retire_stall  out  1  SQ request not granted this cycle
- i_lq_replay_en  in  1  LQ replay request
- i_lq_replay_lsu_func  in  PCYN_LSU_FUNC_WIDTH  load func
- i_lq_replay_select  in  OPTN_LQ_DEPTH  one-hot LQ entry
- i_lq_replay_tag  in  OPTN_ROB_IDX_WIDTH  ROB tag
- i_lq_replay_addr  in  OPTN_ADDR_WIDTH  load address
- o_lq_replay_stall  out  1  LQ request not granted
- i_rs_en  in  1  new op from RS
- i_rs_lsu_func  in  PCYN_LSU_FUNC_WIDTH  func
- i_rs_lq_select  in  OPTN_LQ_DEPTH  allocated LQ entry (loads)
- i_rs_sq_select  in  OPTN_SQ_DEPTH  allocated SQ entry (stores)
- i_rs_tag  in  OPTN_ROB_IDX_WIDTH  ROB tag
- i_rs_addr  in  OPTN_ADDR_WIDTH  effective address
- o_rs_stall  out  1  RS request not granted
- o_valid, o_fill_replay, o_retire  out  1 each  issued-op qualifiers
- o_lsu_func  out  PCYN_LSU_FUNC_WIDTH  func of issued op
- o_lq_select  out  OPTN_LQ_DEPTH  LQ select of issued op
- o_sq_select  out  OPTN_SQ_DEPTH  SQ select of issued op
- o_tag  out  OPTN_ROB_IDX_WIDTH  ROB tag of issued op
- o_addr  out  OPTN_ADDR_WIDTH  address of issued op

Behaviour:
- Reset: o_valid, o_fill_replay, o_retire = 0; starve counter = 0. Data outputs are not reset.
- Grant priority (combinational, same cycle as the request):
  - fill always wins;
  - else if starved (counter == OPTN_STARVE_LIMIT) and i_rs_en, RS wins;
  - else SQ, then LQ, then RS.
- Stall outputs: o_*_stall = request & ~grant, combinational. A stalled requester holds its request and fields stable until granted.
- Registered output, 1-cycle latency: grant in cycle N appears on o_* in cycle N+1.
- Fill grant:
  - o_lsu_func = PCYN_LSU_FUNC_FILL, o_addr = i_fill_addr, o_fill_replay = 1, selects/tag = 0.
  - Not killed by i_flush.
- SQ grant: o_retire = 1, o_sq_select = retire select, o_lq_select = 0.
- LQ grant: o_lq_select = replay select, o_sq_select = 0.
- RS grant: both selects passed through.
- i_flush:
  - Next-cycle o_valid = 0 for any non-fill grant.
  - Stalls still report grant state (the flushed grant is consumed); RS/LQ/SQ are responsible for dropping their requests.
  - Counter is cleared.
- Starve counter (4-bit, saturates at OPTN_STARVE_LIMIT):
  - increments when i_rs_en & o_rs_stall;
  - clears on RS grant, when ~i_rs_en, or on flush.
- Forced RS grant stalls SQ and LQ that cycle; a fill still pre-empts it and the counter holds at its saturated value.
- No requests: next-cycle o_valid = 0, and o_retire = 0, o_fill_replay = 0.

Optional Feature:
- Macro PCYN_LSU_ARB_PERF_EN.
- Defined: adds 32-bit wrapping grant counters per source (fill, sq, lq, rs) and a forced-grant counter. All clear on reset; exposed on outputs o_perf_fill_cnt, o_perf_sq_cnt, o_perf_lq_cnt, o_perf_rs_cnt, o_perf_force_cnt.
- Undefined: no counters and no ports; arbitration is identical.

Decomposition:
- procyon_constants.svh supplies PCYN_LSU_FUNC_* and PCYN_LSU_FUNC_WIDTH.
- Add PCYN_LSU_ARB_SRC_WIDTH = 2 and source encodings PCYN_LSU_ARB_SRC_FILL/SQ/LQ/RS.
- One sub-module: procyon_lsu_starve_cnt (saturating counter with starved flag).

Test Plan:
- Reset, no requests -> o_valid = 0, o_retire = 0, o_fill_replay = 0; counter 0.
- Fill, SQ, LQ and RS all asserted in the same cycle -> next cycle o_lsu_func = FILL, o_fill_replay = 1; SQ, LQ and RS stalls = 1.
- SQ retire (select 8'h04, tag 5'd3) with RS -> next cycle o_retire = 1, o_sq_select = 8'h04, o_valid = 1; o_rs_stall = 1.
- LQ replay held 4 cycles with RS held, LIMIT = 4 -> RS is granted in the 5th cycle; o_lq_replay_stall = 1 that cycle.
- i_flush with RS grant (tag 5'd7) -> next cycle o_valid = 0; counter 0.
- i_flush with fill (addr 32'h1000) -> next cycle o_fill_replay = 1, o_addr = 32'h1000.
